// File: rtl/gshare_bpb_pkg.sv
// Shared definitions for the gshare branch prediction buffer.
//   state_t     : flush-engine FSM states (IDLE, SWEEP)
//   init_value  : counter reset value for a given counter width
//                 (weakly not taken, 2**(w-1)-1)
//   sat_update  : saturating increment/decrement of a w-bit counter
package bpb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  function automatic logic [31:0] init_value(input int cnt_bits);
    return 32'((1 << (cnt_bits - 1)) - 1);
  endfunction

  // Counter is carried in a 32-bit container so one function serves every
  // CNT_BITS; callers truncate the result back to their width.
  function automatic logic [31:0] sat_update(input logic [31:0] cnt,
                                             input logic        taken,
                                             input int          cnt_bits);
    logic [31:0] max_v;
    logic [31:0] res;
    max_v = 32'((1 << cnt_bits) - 1);
    if (taken) res = (cnt == max_v) ? cnt : cnt + 32'd1;
    else       res = (cnt == 32'd0) ? cnt : cnt - 32'd1;
    return res;
  endfunction

endpackage

// File: rtl/gshare_bpb_if.sv
// Bus between the fetch/decode pipeline and the branch prediction buffer.
//   IF_PC                 : fetch PC (IF stage)
//   Pred_Taken/State/Index: combinational prediction for IF_PC
//   Branch/Upd_Index/Upd_Taken : resolution strobe from the ID stage
//   Flush/Busy            : table-clear request and sweep-in-progress flag
//   dbg_state/dbg_ghr     : observability of the FSM state and history
// There is no valid/ready pair here: Branch and Flush are single-cycle
// strobes taken in the cycle they are high; Busy only reports that updates
// are currently being discarded, it never back-pressures the requester.
interface gshare_bpb_if
  import bpb_pkg::*;
#(
  parameter int PC_BITS    = 32,
  parameter int INDEX_BITS = 4,
  parameter int CNT_BITS   = 2,
  parameter int HIST_BITS  = 4
);
  logic [PC_BITS-1:0]    IF_PC;
  logic                  Pred_Taken;
  logic [CNT_BITS-1:0]   Pred_State;
  logic [INDEX_BITS-1:0] Pred_Index;
  logic                  Branch;
  logic [INDEX_BITS-1:0] Upd_Index;
  logic                  Upd_Taken;
  logic                  Flush;
  logic                  Busy;
  state_t                dbg_state;
  logic [HIST_BITS-1:0]  dbg_ghr;

  modport master (
    output IF_PC, Branch, Upd_Index, Upd_Taken, Flush,
    input  Pred_Taken, Pred_State, Pred_Index, Busy, dbg_state, dbg_ghr
  );

  modport slave (
    input  IF_PC, Branch, Upd_Index, Upd_Taken, Flush,
    output Pred_Taken, Pred_State, Pred_Index, Busy, dbg_state, dbg_ghr
  );
endinterface

// File: rtl/gshare_bpb_counter_array.sv
// DEPTH x CNT_BITS table of saturating counters.
//   clk, rst : clock, synchronous reset (all entries to INIT)
//   raddr/rdata : asynchronous read port
//   we, waddr   : single write port
//   wr_init     : 1 = write INIT, 0 = saturating step in direction wtaken
// The read-modify-write of an update happens here, so the write port only
// carries the direction, not a precomputed next state.
module bpb_counter_array
  import bpb_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int CNT_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] raddr,
  output logic [CNT_BITS-1:0]   rdata,
  input  logic                  we,
  input  logic                  wr_init,
  input  logic [INDEX_BITS-1:0] waddr,
  input  logic                  wtaken
);
  localparam int DEPTH = 2 ** INDEX_BITS;
  localparam logic [CNT_BITS-1:0] INIT = CNT_BITS'(init_value(CNT_BITS));

  logic [CNT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT;
    end else if (we) begin
      if (wr_init) mem[waddr] <= INIT;
      else         mem[waddr] <= CNT_BITS'(sat_update(32'(mem[waddr]), wtaken, CNT_BITS));
    end
  end

  // Plain async read: a write in this cycle is seen on the next cycle.
  assign rdata = mem[raddr];

endmodule

// File: rtl/gshare_bpb.sv
// Gshare / bimodal branch prediction buffer with a sequential flush engine.
//   CLK, RST : clock and synchronous active-high reset
//   bus      : gshare_bpb_if slave (prediction, update, flush, debug)
// Prediction is read combinationally for IF_PC; updates use the index the
// branch was predicted with. A flush sweeps every entry back to INIT, one
// per cycle, while predictions read as INIT and updates are discarded.
module gshare_bpb
  import bpb_pkg::*;
#(
  parameter int PC_BITS    = 32,
  parameter int INDEX_BITS = 4,
  parameter int CNT_BITS   = 2,
  parameter int HIST_BITS  = 4,
  parameter int GSHARE     = 1
) (
  input logic        CLK,
  input logic        RST,
  gshare_bpb_if.slave bus
);
  localparam int DEPTH = 2 ** INDEX_BITS;
  localparam logic [CNT_BITS-1:0]   INIT     = CNT_BITS'(init_value(CNT_BITS));
  localparam logic [INDEX_BITS-1:0] LAST_PTR = INDEX_BITS'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;

  logic                  we;
  logic                  wr_init;
  logic [INDEX_BITS-1:0] waddr;
  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] pred_idx;
  logic [CNT_BITS-1:0]   rdata;
  logic                  unused_pc_bits;

  // Index hashing
  assign pc_idx   = bus.IF_PC[INDEX_BITS+1:2];
  assign pred_idx = (GSHARE != 0) ? (pc_idx ^ INDEX_BITS'(ghr_q)) : pc_idx;
  assign unused_pc_bits = ^{bus.IF_PC[PC_BITS-1:INDEX_BITS+2], bus.IF_PC[1:0]};

  bpb_counter_array #(
    .INDEX_BITS (INDEX_BITS),
    .CNT_BITS   (CNT_BITS)
  ) u_array (
    .clk     (CLK),
    .rst     (RST),
    .raddr   (pred_idx),
    .rdata   (rdata),
    .we      (we),
    .wr_init (wr_init),
    .waddr   (waddr),
    .wtaken  (bus.Upd_Taken)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ghr_q   <= ghr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ghr_d   = ghr_q;
    we      = 1'b0;
    wr_init = 1'b0;
    waddr   = bus.Upd_Index;
    case (state_q)
      IDLE: begin
        if (bus.Flush) begin
          // Flush wins over a same-cycle Branch: that update is dropped.
          state_d = SWEEP;
          ptr_d   = '0;
          ghr_d   = '0;
        end else if (bus.Branch) begin
          we    = 1'b1;
          // Low HIST_BITS of {ghr, taken} is the shifted history; this also
          // covers HIST_BITS == 1 without a separate case.
          ghr_d = HIST_BITS'({ghr_q, bus.Upd_Taken});
        end
      end
      SWEEP: begin
        we      = 1'b1;
        wr_init = 1'b1;
        waddr   = ptr_q;
        if (bus.Flush) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + INDEX_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // During a sweep the array is partially stale, so present INIT instead.
  assign bus.Pred_State = (state_q == SWEEP) ? INIT : rdata;
  assign bus.Pred_Taken = bus.Pred_State[CNT_BITS-1];
  assign bus.Pred_Index = pred_idx;
  assign bus.Busy       = (state_q == SWEEP);
  assign bus.dbg_state  = state_q;
  assign bus.dbg_ghr    = ghr_q;

endmodule
